// File: rtl/bcd_seg7_scanner_pkg.sv
// rtl/bcd_seg7_scanner_pkg.sv - shared segment patterns and slot-state enum
//
// Purpose: constants and types shared by the seven-segment scanner and its
// decoder. Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
// Ports: none (package).
package bcd_seg7_scanner_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic {
    GUARD_OFF = 1'b0,
    DRIVE     = 1'b1
  } slot_state_t;

endpackage

// File: rtl/bcd_seg7_scanner_decode.sv
// rtl/bcd_seg7_scanner_decode.sv - combinational BCD to seven-segment decoder
//
// Purpose: maps one BCD digit to its active-low segment pattern; codes
// 10..15 render as a dash so corrupt upstream data is visible.
// Ports:
//   digit - 4-bit BCD code
//   seg   - 7-bit active-low pattern {g,f,e,d,c,b,a}
module seg7_decode
  import bcd_seg7_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// rtl/bcd_seg7_scanner.sv - four-digit multiplexed seven-segment scanner
//
// Purpose: time-multiplexes four BCD digits onto a common-segment display,
// with a guard interval per slot (all anodes off) to suppress ghosting,
// frame-synchronous update of the displayed value and leading-zero blanking.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bcd_in    - four packed BCD digits, [15:12] thousands .. [3:0] units
//   load      - one-cycle strobe capturing bcd_in
//   blank_lz  - enable leading-zero blanking
//   seg       - active-low segments {g,f,e,d,c,b,a} (registered)
//   an        - active-low anodes, an[0] = units (registered)
//   upd_pend  - a loaded value waits for the next frame boundary
module bcd_seg7_scanner
  import bcd_seg7_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        upd_pend
);

  localparam int             CW         = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  GUARD_LAST = CW'(GUARD - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    idx;
  logic          commit_tick;
  slot_state_t   state, state_nxt;

  logic [15:0]   disp;
  logic [15:0]   pend;

  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic          lz3, lz2, lz1;
  logic          blank_cur;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;

  assign tick        = (cnt == CNT_LAST);
  assign commit_tick = tick && (idx == 2'd3);

  // Prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Slot FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= GUARD_OFF;
    else     state <= state_nxt;
  end

  // Slot FSM: next state. The guard interval covers counts 0..GUARD-1, so
  // the switch to DRIVE happens on the edge leaving count GUARD-1.
  always_comb begin
    state_nxt = state;
    if (tick)
      state_nxt = GUARD_OFF;
    else if (state == GUARD_OFF && cnt == GUARD_LAST)
      state_nxt = DRIVE;
  end

  // Pending/display registers. The display only changes on the frame-wrap
  // tick so a frame never shows a mix of old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp     <= 16'h0000;
      pend     <= 16'h0000;
      upd_pend <= 1'b0;
    end else if (commit_tick) begin
      if (load) begin
        disp <= bcd_in;
        pend <= bcd_in;
      end else if (upd_pend) begin
        disp <= pend;
      end
      upd_pend <= 1'b0;
    end else if (load) begin
      pend     <= bcd_in;
      upd_pend <= 1'b1;
    end
  end

  // Digit selection and leading-zero detection
  always_comb begin
    cur_digit = disp[3:0];
    case (idx)
      2'd0: cur_digit = disp[3:0];
      2'd1: cur_digit = disp[7:4];
      2'd2: cur_digit = disp[11:8];
      2'd3: cur_digit = disp[15:12];
      default: cur_digit = disp[3:0];
    endcase
  end

  assign lz3 = (disp[15:12] == 4'd0);
  assign lz2 = lz3 && (disp[11:8] == 4'd0);
  assign lz1 = lz2 && (disp[7:4] == 4'd0);

  // Units digit is never blanked, so a zero value still shows "0".
  always_comb begin
    blank_cur = 1'b0;
    case (idx)
      2'd1:    blank_cur = blank_lz && lz1;
      2'd2:    blank_cur = blank_lz && lz2;
      2'd3:    blank_cur = blank_lz && lz3;
      default: blank_cur = 1'b0;
    endcase
  end

  seg7_decode u_decode (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Slot FSM: outputs, computed from current state and registered below
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (state == DRIVE) begin
      an_d      = AN_OFF;
      an_d[idx] = 1'b0;
      seg_d     = blank_cur ? SEG_BLANK : cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// tb/tb_bcd_seg7_scanner.sv - self-checking bench for bcd_seg7_scanner
module tb_bcd_seg7_scanner;

  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = 4 * SCAN_DIV;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_pend;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } obs_t;

  typedef struct {
    logic [15:0] bcd;
    logic        blz;
    logic [27:0] segs;   // {thousands, hundreds, tens, units}
  } vec_t;

  obs_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  bcd_seg7_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .upd_pend (upd_pend)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge right after a frame-start edge (commit or reset
  // release). Pushes the expected output for every cycle of the coming frame,
  // then pops one entry per observed cycle.
  task automatic check_frame(input string name, input logic [27:0] segs);
    obs_t e;
    for (int p = 0; p < FRAME; p++) begin
      int slot, c;
      slot = p / SCAN_DIV;
      c    = p % SCAN_DIV;
      if (c < GUARD) begin
        e.an  = 4'b1111;
        e.seg = SB;
      end else begin
        e.an  = 4'b1111 & ~(4'b0001 << slot);
        e.seg = segs[slot*7 +: 7];
      end
      sb.push_back(e);
    end
    for (int p = 0; p < FRAME; p++) begin
      @(negedge clk);
      e = sb.pop_front();
      check({name, "_an"}, {28'd0, an}, {28'd0, e.an});
      check({name, "_seg"}, {25'd0, seg}, {25'd0, e.seg});
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bcd_in = v;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_commit(input string name);
    int k;
    k = 0;
    while (upd_pend === 1'b1 && k < 3 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check({name, "_commit_timeout"}, {31'd0, upd_pend}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b0, {S1, S2, S3, S4}};
    vecs[1] = '{16'h0042, 1'b1, {SB, SB, S4, S2}};
    vecs[2] = '{16'h0000, 1'b1, {SB, SB, SB, S0}};
    vecs[3] = '{16'h9ABF, 1'b0, {S9, SD, SD, SD}};
    vecs[4] = '{16'h5678, 1'b0, {S5, S6, S7, S8}};
    vecs[5] = '{16'h0900, 1'b1, {SB, S9, S0, S0}};
    vecs[6] = '{16'h0000, 1'b0, {S0, S0, S0, S0}};
    vecs[7] = '{16'h3000, 1'b1, {S3, S0, S0, S0}};

    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = 16'h0000;
    blank_lz = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_upd_pend", {31'd0, upd_pend}, 32'd0);

    // First frame after release: guard cycle, then units "0"
    rst = 1'b0;
    check_frame("post_rst", {S0, S0, S0, S0});

    // Table-driven loads, each committed at a frame boundary
    for (int i = 0; i < 8; i++) begin
      blank_lz = vecs[i].blz;
      do_load(vecs[i].bcd);
      check($sformatf("v%0d_pend", i), {31'd0, upd_pend}, 32'd1);
      wait_commit($sformatf("v%0d", i));
      check_frame($sformatf("v%0d", i), vecs[i].segs);
    end

    // Two loads in one frame: last wins, the first never reaches the display
    begin
      int seen1;
      int k;
      seen1    = 0;
      blank_lz = 1'b0;
      do_load(16'h1111);
      @(negedge clk);
      do_load(16'h2222);
      check("dbl_pend", {31'd0, upd_pend}, 32'd1);
      k = 0;
      while (upd_pend === 1'b1 && k < 3 * FRAME) begin
        @(negedge clk);
        if (seg == S1) seen1++;
        k++;
      end
      check("dbl_commit_timeout", {31'd0, upd_pend}, 32'd0);
      check_frame("dbl", {S2, S2, S2, S2});
      check("dbl_no_1111", seen1, 32'd0);
    end

    // Load coinciding with the commit tick commits on that same edge
    repeat (FRAME - 1) @(negedge clk);
    bcd_in = 16'h4321;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    check("coinc_pend", {31'd0, upd_pend}, 32'd0);
    check_frame("coinc", {S4, S3, S2, S1});

    // Reset mid-frame with data pending, together with a load
    do_load(16'h7777);
    check("midrst_pend_set", {31'd0, upd_pend}, 32'd1);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    bcd_in = 16'h5555;
    load   = 1'b1;
    @(negedge clk);
    check("midrst_an", {28'd0, an}, 32'hF);
    check("midrst_seg", {25'd0, seg}, 32'h7F);
    check("midrst_pend_clr", {31'd0, upd_pend}, 32'd0);
    rst  = 1'b0;
    load = 1'b0;
    check_frame("midrst_f0", {S0, S0, S0, S0});
    check_frame("midrst_f1", {S0, S0, S0, S0});
    check("midrst_pend_final", {31'd0, upd_pend}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_scanner.md
BCD_SEG7_SCANNER -- requirements
Module: bcd_seg7_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 Parameter GUARD, default 2, cycles per slot with all anodes off for ghost suppression (1 <= GUARD < SCAN_DIV).
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge only.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 bcd_in  in  16  four packed BCD digits, [15:12]=thousands ... [3:0]=units, same packing as the upstream binary-to-BCD converter.
REQ-006 load  in  1  single-cycle strobe; captures bcd_in.
REQ-007 blank_lz  in  1  1 = leading-zero blanking enabled.
REQ-008 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-009 an  out  4  active-low digit anodes, an[k] selects digit k (k=0 units).
REQ-010 upd_pend  out  1  1 = a loaded value is waiting for the next frame commit.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL assert in the cycle where the count equals SCAN_DIV-1.
REQ-012 Digit index SHALL advance 0->1->2->3->0 on each tick; one frame = 4*SCAN_DIV cycles.
REQ-013 Slot FSM: GUARD_OFF for prescaler counts 0..GUARD-1, then DRIVE until the tick; on tick return to GUARD_OFF.
REQ-014 In GUARD_OFF, an SHALL be 4'b1111 and seg 7'b1111111.
REQ-015 In DRIVE, an SHALL be all ones except bit idx low, and seg SHALL be the decoded display digit idx.
REQ-016 seg and an SHALL be registered: they reflect the FSM/index state of the previous cycle (1-cycle latency).
REQ-017 Decode (active low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Digit codes 10..15 SHALL display a dash: 0111111.
REQ-019 load SHALL write bcd_in into a pending register and set upd_pend; a load while upd_pend=1 SHALL overwrite pending (last wins).
REQ-020 Commit: on the tick with idx=3 (frame wrap), if upd_pend=1 the display register SHALL take the pending value and upd_pend SHALL clear.
REQ-021 load in the same cycle as a commit tick SHALL commit bcd_in directly to the display register and leave upd_pend=0.
REQ-022 The display register SHALL NOT change at any other time (no tearing mid-frame).
REQ-023 With blank_lz=1, digit k (k=3,2,1) SHALL be blanked (seg=1111111, anode still driven) when display digits k..3 are all zero; digit 0 SHALL never be blanked.
REQ-024 blank_lz SHALL be sampled combinationally each cycle (takes effect on the next registered output).

Reset
REQ-025 While rst=1: prescaler=0, idx=0, FSM=GUARD_OFF, display=16'h0000, pending=16'h0000, upd_pend=0, an=4'b1111, seg=7'b1111111.
REQ-026 rst SHALL override a simultaneous load; reset mid-frame SHALL discard pending data.
REQ-027 First DRIVE after reset release SHALL occur GUARD+1 cycles later, on digit 0, showing "0".

Structure
REQ-028 Shared package: segment pattern constants (digits 0-9, dash, blank) and slot-state enum.
REQ-029 One sub-module seg7_decode (4-bit BCD in, 7-bit active-low pattern out, purely combinational) SHALL hold the REQ-017/018 table.
REQ-030 Prescaler, index, FSM, pending/commit logic SHALL reside in bcd_seg7_scanner.

Verification (SCAN_DIV=4, GUARD=1)
REQ-031 Reset release, no load -> cycle 1 an=1111; cycle 2 an=1110 seg=1000000; digits 1-3 show 1000000 with blank_lz=0.
REQ-032 load bcd_in=16'h1234 mid-frame -> upd_pend=1 until idx 3->0 tick, then units=0011001, tens=0110000, hundreds=0100100, thousands=1111001.
REQ-033 display 16'h0042, blank_lz=1 -> an=0111 and an=1011 slots show seg=1111111; tens=0011001, units=0100100; display 16'h0000 -> only units shows 1000000.
REQ-034 Two loads (16'h1111 then 16'h2222) inside one frame -> only 2222 ever displayed; load coinciding with commit tick -> committed same edge, upd_pend stays 0.
REQ-035 bcd_in=16'h9ABF -> thousands 0010000, other three digits 0111111.
REQ-036 rst asserted mid-frame with upd_pend=1 -> next cycle an=1111, upd_pend=0, display 0000 after release.
